// File: rtl/outperiph_pkg.sv
// Shared register-map encodings and the byte-lane merge helper for the output peripheral bank.
package outperiph_pkg;

  typedef enum logic [1:0] {
    REG_DATA  = 2'd0,
    REG_SET   = 2'd1,
    REG_CLR   = 2'd2,
    REG_BLINK = 2'd3
  } reg_off_e;

  typedef enum logic [1:0] {
    CTL_CTRL = 2'd0,
    CTL_DIV  = 2'd1,
    CTL_STAT = 2'd2,
    CTL_RSVD = 2'd3
  } ctl_off_e;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be_b);
    return be_b ? new_b : old_b;
  endfunction

endpackage

// File: rtl/outperiph_blink_prescaler.sv
// Free-running prescaler that toggles the shared blink phase every div+1 enabled cycles.
module blink_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             div_wr,
  output logic             phase,
  output logic [DIV_W-1:0] count
);

  // A divider rewrite restarts the count so a smaller div can never be skipped past.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      count <= '0;
      phase <= 1'b0;
    end else if (div_wr) begin
      count <= '0;
    end else if (count == div) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/outperiph_bank.sv
// Memory-mapped output channel bank: DATA/SET/CLR/BLINK per channel plus a control slot
// driving a shared blink phase that is XORed onto each channel through its mask.
module outperiph_bank
  import outperiph_pkg::*;
#(
  parameter int NUM_CH    = 11,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int DIV_W     = 24,
  parameter int DIV_RESET = 4_999_999
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     wren,
  input  logic [DATA_W/8-1:0]      be,
  output logic [DATA_W-1:0]        rdata,
  output logic [NUM_CH*DATA_W-1:0] ch_out,
  output logic                     phase
);

  localparam int NB = DATA_W / 8;
  localparam int SW = ADDR_W - 4;
  localparam logic [SW-1:0]    CTL_SLOT = SW'(NUM_CH);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DIV_RESET);

  if (NUM_CH < 1 || NUM_CH > 15 || (NUM_CH + 1) * 16 > 2 ** ADDR_W ||
      DATA_W % 8 != 0 || DIV_W + 1 > DATA_W) begin : g_bad_params
    $error("outperiph_bank: illegal parameter combination");
  end

  logic [SW-1:0] slot;
  reg_off_e      roff;
  ctl_off_e      coff;
  assign slot = addr[ADDR_W-1:4];
  assign roff = reg_off_e'(addr[3:2]);
  assign coff = ctl_off_e'(addr[3:2]);

  logic [NUM_CH-1:0][DATA_W-1:0] data_q, blink_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_W-1:0] data_r, blink_r, d_n, b_n;
    logic              sel;
    assign sel = wren && (slot == SW'(i));

    always_comb begin
      d_n = data_r;
      b_n = blink_r;
      for (int k = 0; k < NB; k++) begin
        case (roff)
          REG_DATA:  d_n[8*k +: 8] = byte_merge(data_r[8*k +: 8], wdata[8*k +: 8], be[k]);
          REG_SET:   d_n[8*k +: 8] = byte_merge(data_r[8*k +: 8],
                                                data_r[8*k +: 8] | wdata[8*k +: 8], be[k]);
          REG_CLR:   d_n[8*k +: 8] = byte_merge(data_r[8*k +: 8],
                                                data_r[8*k +: 8] & ~wdata[8*k +: 8], be[k]);
          REG_BLINK: b_n[8*k +: 8] = byte_merge(blink_r[8*k +: 8], wdata[8*k +: 8], be[k]);
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_r  <= '0;
        blink_r <= '0;
      end else if (sel) begin
        data_r  <= d_n;
        blink_r <= b_n;
      end
    end

    assign data_q[i]  = data_r;
    assign blink_q[i] = blink_r;
    assign ch_out[i*DATA_W +: DATA_W] = data_r ^ (blink_r & {DATA_W{phase}});
  end

  logic              ctl_sel, ctrl_wr, div_wr, blink_en_q, en_eff;
  logic [DIV_W-1:0]  div_q, count;
  logic [DATA_W-1:0] div_ext, div_mrg;

  assign ctl_sel = wren && (slot == CTL_SLOT);
  assign ctrl_wr = ctl_sel && (coff == CTL_CTRL) && be[0];
  assign div_wr  = ctl_sel && (coff == CTL_DIV);

  // Clearing blink_en zeroes the engine on the same edge; setting it starts from 0 next cycle.
  assign en_eff = blink_en_q && !(ctrl_wr && !wdata[0]);

  always_comb begin
    div_ext = DATA_W'(div_q);
    div_mrg = div_ext;
    for (int k = 0; k < NB; k++)
      div_mrg[8*k +: 8] = byte_merge(div_ext[8*k +: 8], wdata[8*k +: 8], be[k]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_en_q <= 1'b0;
      div_q      <= DIV_RST;
    end else begin
      if (ctrl_wr) blink_en_q <= wdata[0];
      if (div_wr)  div_q      <= div_mrg[DIV_W-1:0];
    end
  end

  blink_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .en     (en_eff),
    .div    (div_q),
    .div_wr (div_wr),
    .phase  (phase),
    .count  (count)
  );

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (slot == SW'(i)) rdata = (roff == REG_BLINK) ? blink_q[i] : data_q[i];
    if (slot == CTL_SLOT) begin
      case (coff)
        CTL_CTRL: rdata = DATA_W'(blink_en_q);
        CTL_DIV:  rdata = DATA_W'(div_q);
        CTL_STAT: rdata = DATA_W'({count, phase});
        default:  rdata = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], div_mrg[DATA_W-1:DIV_W]};

endmodule
